// File: rtl/memory_access_stage.sv
// Memory stage: DM_DEPTH x 32 data memory, load/store formatting, M->WB register (1-cycle latency); stall holds WB, flush/invalid loads a bubble.
// MEM_SUBWORD_EN enables byte/half accesses; without it every access is a word access and funct3_M is ignored.
module memory_access_stage #(
  parameter int DM_DEPTH = 256,
  parameter int DM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Alu_out_M,
  input  logic [31:0] WD_M,
  input  logic [4:0]  RD_M,
  input  logic        RF_WE_M,
  input  logic        ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic        valid_M,
  input  logic [2:0]  funct3_M,
  input  logic        stall_M,
  input  logic        flush_M,
  output logic [31:0] Alu_out_WB,
  output logic [31:0] DM_RD_out_WB,
  output logic [4:0]  RD_WB,
  output logic        RF_WE_WB,
  output logic        ResultSrc_WB,
  output logic        misalign_err
);

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] dm_rd;
    logic [4:0]  rd;
    logic        rf_we;
    logic        res_src;
  } wb_t;

  logic [31:0] mem [DM_DEPTH];

  wb_t         wb_q, wb_d;
  logic        misalign_err_q, misalign_err_d;

  logic [DM_AW-1:0] idx;
  logic [1:0]       off;
  logic [31:0]      rd_word;
  logic             is_load;
  logic             advance;
  logic             is_byte, is_half, is_unsigned;
  logic             misalign;
  logic [31:0]      load_dat;
  logic [31:0]      wr_mask, wr_val, wr_dat;
  logic             mem_we;

  assign idx     = Alu_out_M[DM_AW+1:2];
  assign off     = Alu_out_M[1:0];
  assign rd_word = mem[idx];
  assign is_load = ResultSrc_M;
  assign advance = valid_M & ~flush_M & ~stall_M;

  // Store codes 100/101 are not defined, so only loads decode them as sub-word.
  always_comb begin
    is_byte     = 1'b0;
    is_half     = 1'b0;
    is_unsigned = 1'b0;
`ifdef MEM_SUBWORD_EN
    is_byte     = (funct3_M == 3'b000) || (!MemWrite_M && funct3_M == 3'b100);
    is_half     = (funct3_M == 3'b001) || (!MemWrite_M && funct3_M == 3'b101);
    is_unsigned = funct3_M[2];
`endif
  end

  always_comb begin
    misalign = 1'b0;
    if (is_half)
      misalign = off[0];
    else if (!is_byte)
      misalign = (off != 2'b00);
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    case (off)
      2'd0: b = rd_word[7:0];
      2'd1: b = rd_word[15:8];
      2'd2: b = rd_word[23:16];
      default: b = rd_word[31:24];
    endcase
    h = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_dat = rd_word;
    if (is_byte)
      load_dat = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
    else if (is_half)
      load_dat = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
  end

  // Sub-word stores merge into the current word so untouched lanes survive.
  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    wr_val  = WD_M;
    if (is_byte) begin
      wr_mask = 32'h0000_00FF << {off, 3'b000};
      wr_val  = {4{WD_M[7:0]}};
    end else if (is_half) begin
      wr_mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      wr_val  = {2{WD_M[15:0]}};
    end
    wr_dat = (rd_word & ~wr_mask) | (wr_val & wr_mask);
  end

  assign mem_we = rst_n & advance & MemWrite_M & ~misalign;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= wr_dat;
  end

  always_comb begin
    wb_d           = wb_q;
    misalign_err_d = misalign_err_q;
    if (flush_M || !valid_M) begin
      wb_d = '0;
    end else if (!stall_M) begin
      wb_d.alu     = Alu_out_M;
      wb_d.dm_rd   = load_dat;
      wb_d.rd      = RD_M;
      wb_d.rf_we   = RF_WE_M & ~(is_load & misalign);
      wb_d.res_src = ResultSrc_M;
      if ((MemWrite_M || is_load) && misalign)
        misalign_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q           <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      wb_q           <= wb_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign Alu_out_WB   = wb_q.alu;
  assign DM_RD_out_WB = wb_q.dm_rd;
  assign RD_WB        = wb_q.rd;
  assign RF_WE_WB     = wb_q.rf_we;
  assign ResultSrc_WB = wb_q.res_src;
  assign misalign_err = misalign_err_q;

  // Upper address bits wrap; funct3_M only matters with sub-word support.
`ifdef MEM_SUBWORD_EN
  logic unused_ok;
  assign unused_ok = ^Alu_out_M[31:DM_AW+2];
`else
  logic unused_ok;
  assign unused_ok = ^{Alu_out_M[31:DM_AW+2], funct3_M};
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: hand-computed vectors, one check per observed output.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Alu_out_M, WD_M;
  logic [4:0]  RD_M;
  logic        RF_WE_M, ResultSrc_M, MemWrite_M, valid_M;
  logic [2:0]  funct3_M;
  logic        stall_M, flush_M;
  logic [31:0] Alu_out_WB, DM_RD_out_WB;
  logic [4:0]  RD_WB;
  logic        RF_WE_WB, ResultSrc_WB, misalign_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] w10;

  memory_access_stage #(.DM_DEPTH(256), .DM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Alu_out_M(Alu_out_M), .WD_M(WD_M), .RD_M(RD_M),
    .RF_WE_M(RF_WE_M), .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
    .valid_M(valid_M), .funct3_M(funct3_M), .stall_M(stall_M), .flush_M(flush_M),
    .Alu_out_WB(Alu_out_WB), .DM_RD_out_WB(DM_RD_out_WB), .RD_WB(RD_WB),
    .RF_WE_WB(RF_WE_WB), .ResultSrc_WB(ResultSrc_WB), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one M-stage operation, then sample just after the next rising edge.
  task automatic op(input logic v, input logic mw, input logic rs, input logic we,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, input logic st, input logic fl);
    valid_M = v;  MemWrite_M = mw; ResultSrc_M = rs; RF_WE_M = we;
    funct3_M = f3; Alu_out_M = a; WD_M = wd; RD_M = rd;
    stall_M = st; flush_M = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    op(1, 1, 0, 0, 3'b010, a, d, 5'd0, 0, 0);
  endtask

  task automatic lw(input logic [31:0] a, input logic [4:0] rd);
    op(1, 0, 1, 1, 3'b010, a, 32'h0, rd, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    op(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
    chk("rst_alu", Alu_out_WB, 32'h0);
    chk("rst_dm", DM_RD_out_WB, 32'h0);
    chk("rst_rd", {27'h0, RD_WB}, 32'h0);
    chk("rst_rfwe", {31'h0, RF_WE_WB}, 32'h0);
    chk("rst_rsrc", {31'h0, ResultSrc_WB}, 32'h0);
    chk("rst_err", {31'h0, misalign_err}, 32'h0);
    rst_n = 1'b1;

    sw(32'h10, 32'hDEAD_BEEF);
    chk("sw_alu", Alu_out_WB, 32'h10);
    chk("sw_rfwe", {31'h0, RF_WE_WB}, 32'h0);
    lw(32'h10, 5'd5);
    chk("lw_data", DM_RD_out_WB, 32'hDEAD_BEEF);
    chk("lw_rfwe", {31'h0, RF_WE_WB}, 32'h1);
    chk("lw_rsrc", {31'h0, ResultSrc_WB}, 32'h1);
    chk("lw_rd", {27'h0, RD_WB}, 32'd5);

`ifdef MEM_SUBWORD_EN
    op(1, 0, 1, 1, 3'b000, 32'h13, 32'h0, 5'd6, 0, 0);
    chk("lb_13", DM_RD_out_WB, 32'hFFFF_FFDE);
    op(1, 0, 1, 1, 3'b100, 32'h13, 32'h0, 5'd6, 0, 0);
    chk("lbu_13", DM_RD_out_WB, 32'h0000_00DE);
    op(1, 0, 1, 1, 3'b101, 32'h10, 32'h0, 5'd6, 0, 0);
    chk("lhu_10", DM_RD_out_WB, 32'h0000_BEEF);
    op(1, 0, 1, 1, 3'b001, 32'h12, 32'h0, 5'd6, 0, 0);
    chk("lh_12", DM_RD_out_WB, 32'hFFFF_DEAD);
    op(1, 1, 0, 0, 3'b000, 32'h11, 32'h0000_0055, 5'd0, 0, 0);
    w10 = 32'hDEAD_55EF;
`else
    // funct3 is ignored: a "byte" load returns the whole word, a "byte" store writes it.
    op(1, 0, 1, 1, 3'b000, 32'h10, 32'h0, 5'd6, 0, 0);
    chk("lb_as_word", DM_RD_out_WB, 32'hDEAD_BEEF);
    op(1, 1, 0, 0, 3'b000, 32'h10, 32'h0000_0055, 5'd0, 0, 0);
    w10 = 32'h0000_0055;
`endif
    lw(32'h10, 5'd6);
    chk("lw_after_sub", DM_RD_out_WB, w10);
    chk("err_clean", {31'h0, misalign_err}, 32'h0);

    sw(32'h20, 32'hCAFE_F00D);
    sw(32'h22, 32'h1234_5678);
    chk("mis_sw_err", {31'h0, misalign_err}, 32'h1);
    lw(32'h20, 5'd3);
    chk("mis_sw_nowr", DM_RD_out_WB, 32'hCAFE_F00D);
    chk("err_sticky", {31'h0, misalign_err}, 32'h1);
    lw(32'h21, 5'd7);
    chk("mis_lw_rfwe", {31'h0, RF_WE_WB}, 32'h0);

    sw(32'h40, 32'h0000_0000);
    sw(32'h44, 32'h55AA_55AA);
    lw(32'h20, 5'd3);
    for (int i = 0; i < 3; i++) begin
      op(1, 1, 0, 0, 3'b010, 32'h44, 32'hBADB_AD01, 5'd0, 1, 0);
      chk("stall_alu", Alu_out_WB, 32'h20);
      chk("stall_rd", {27'h0, RD_WB}, 32'd3);
      chk("stall_dm", DM_RD_out_WB, 32'hCAFE_F00D);
    end
    sw(32'h40, 32'h1111_2222);
    chk("rel_alu", Alu_out_WB, 32'h40);
    lw(32'h40, 5'd8);
    chk("rel_wr", DM_RD_out_WB, 32'h1111_2222);
    lw(32'h44, 5'd8);
    chk("stall_nowr", DM_RD_out_WB, 32'h55AA_55AA);

    op(1, 1, 0, 0, 3'b010, 32'h44, 32'hBADB_AD02, 5'd4, 1, 1);
    chk("fl_alu", Alu_out_WB, 32'h0);
    chk("fl_dm", DM_RD_out_WB, 32'h0);
    chk("fl_rd", {27'h0, RD_WB}, 32'h0);
    chk("fl_rfwe", {31'h0, RF_WE_WB}, 32'h0);
    lw(32'h44, 5'd8);
    chk("fl_nowr", DM_RD_out_WB, 32'h55AA_55AA);
    op(0, 0, 1, 1, 3'b010, 32'h40, 32'h0, 5'd9, 0, 0);
    chk("inv_alu", Alu_out_WB, 32'h0);
    chk("inv_rsrc", {31'h0, ResultSrc_WB}, 32'h0);

    lw(32'h40, 5'd9);
    rst_n = 1'b0;
    sw(32'h40, 32'hFFFF_0000);
    chk("mrst_alu", Alu_out_WB, 32'h0);
    chk("mrst_dm", DM_RD_out_WB, 32'h0);
    chk("mrst_rfwe", {31'h0, RF_WE_WB}, 32'h0);
    chk("mrst_err", {31'h0, misalign_err}, 32'h0);
    rst_n = 1'b1;
    lw(32'h40, 5'd9);
    chk("mrst_nowr", DM_RD_out_WB, 32'h1111_2222);
    lw(32'h10, 5'd9);
    chk("mrst_keep", DM_RD_out_WB, w10);

    sw(32'h410, 32'h0BAD_F00D);
    lw(32'h10, 5'd2);
    chk("wrap", DM_RD_out_WB, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL have parameter DM_DEPTH, default 256, giving the number of 32-bit data-memory words.
REQ-002 The block SHALL have parameter DM_AW, default 8, giving the word-address width (log2 DM_DEPTH).
REQ-003 The block SHALL have a single clock and a synchronous active-low reset; the clock and reset are named following the codebase convention (clock named clk; reset named rst_n to mark active-low).
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 Alu_out_M  input  32  ALU result / effective byte address.
REQ-007 WD_M  input  32  store data.
REQ-008 RD_M  input  5  destination register.
REQ-009 RF_WE_M, ResultSrc_M, MemWrite_M, valid_M  input  1 each  register write enable, result select (1 = memory), store enable, instruction valid.
REQ-010 funct3_M  input  3  access size/sign code.
REQ-011 stall_M, flush_M  input  1 each  hold stage; squash instruction in M.
REQ-012 Alu_out_WB, DM_RD_out_WB  output  32 each  registered ALU result and load data, to write-back.
REQ-013 RD_WB  output  5; RF_WE_WB, ResultSrc_WB  output  1 each  registered controls, to write-back.
REQ-014 misalign_err  output  1  sticky misaligned-access flag.

Function
REQ-015 The block SHALL contain a DM_DEPTH x 32 data memory indexed by Alu_out_M[DM_AW+1:2]; upper address bits are ignored (wrap-around).
REQ-016 The block SHALL read memory combinationally in M and capture the formatted load data into DM_RD_out_WB at the rising edge, giving a one-cycle M-to-WB latency.
REQ-017 The block SHALL write memory at the rising edge only when valid_M=1, MemWrite_M=1, stall_M=0, flush_M=0 and the access is aligned.
REQ-018 A load in the cycle after a store to the same word SHALL return the newly stored data.
REQ-019 Load formatting: funct3 000 LB sign-extended, 001 LH sign-extended, 010 LW, 100 LBU zero-extended, 101 LHU zero-extended; byte/half lane chosen by Alu_out_M[1:0].
REQ-020 Store formatting: funct3 000 SB writes one byte lane, 001 SH writes one half lane, 010 SW writes the full word; unwritten lanes are preserved.
REQ-021 Unlisted funct3 codes SHALL be treated as word access.
REQ-022 Misaligned means half access with Alu_out_M[0]=1 or word access with Alu_out_M[1:0]!=00; only valid, unflushed, unstalled loads/stores are checked.
REQ-023 On a misaligned store the write SHALL be suppressed; on a misaligned load RF_WE_WB SHALL be registered as 0; in both cases misalign_err SHALL set and stay set until reset.
REQ-024 stall_M=1 with flush_M=0 SHALL hold all WB outputs and suppress memory writes.
REQ-025 flush_M=1 SHALL load a bubble (all WB outputs 0) and suppress the write; flush has priority over stall.
REQ-026 valid_M=0 SHALL load a bubble identical to flush.
REQ-027 Alu_out_WB, RD_WB and ResultSrc_WB SHALL be registered copies of the M inputs when the stage advances.

Reset
REQ-028 With rst_n=0 at a rising edge, Alu_out_WB, DM_RD_out_WB, RD_WB, RF_WE_WB, ResultSrc_WB and misalign_err SHALL all become 0.
REQ-029 Reset SHALL take priority over stall and flush, and no memory write SHALL occur in a reset cycle.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro MEM_SUBWORD_EN defined: byte/half loads and stores SHALL behave per REQ-019/020/022.
REQ-032 MEM_SUBWORD_EN undefined: all accesses SHALL be word accesses, funct3_M SHALL be ignored, and the misalignment check SHALL use Alu_out_M[1:0]!=00 only.

Verification
REQ-033 SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle -> DM_RD_out_WB=0xDEADBEEF one cycle later, RF_WE_WB=1, ResultSrc_WB=1.
REQ-034 With MEM_SUBWORD_EN, after REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x10 -> 0x0000BEEF; SB 0x55 to 0x11 then LW 0x10 -> 0xDEAD55EF.
REQ-035 SW 0x12345678 to 0x22 -> word 0x20 unchanged, misalign_err=1; it remains 1 through later aligned traffic until rst_n=0.
REQ-036 Stall for 3 cycles during an SW to 0x40 -> WB outputs held, memory written once only after the stall is released; flush_M=1 together with stall_M=1 -> bubble, no write.
REQ-037 Assert rst_n=0 mid-stream with a store pending -> all outputs 0 at the next edge; store not performed; earlier memory contents intact.
